// File: rtl/fnd_pkg.sv
// Shared constants, FSM state type and BCD adjust helper for the FND scan path.
package fnd_pkg;

    localparam int unsigned FND_DIGITS = 4;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned BIN_W      = 14;
    localparam int unsigned MAX_VALUE  = 9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    // Double-dabble correction: add 3 to every nibble that is 5 or more.
    function automatic logic [FND_DIGITS*BCD_W-1:0] add3(input logic [FND_DIGITS*BCD_W-1:0] s);
        logic [FND_DIGITS*BCD_W-1:0] r;
        r = s;
        for (int unsigned i = 0; i < FND_DIGITS; i++) begin
            if (s[i*BCD_W +: BCD_W] >= 4'd5) begin
                r[i*BCD_W +: BCD_W] = s[i*BCD_W +: BCD_W] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/binary_to_bcd_seq.sv
// Handshaked 14-bit binary to 4-digit BCD converter using a sequential
// shift-and-add-3 engine; values above 9999 are clamped and flagged.
module binary_to_bcd_seq
    import fnd_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         valid,
    input  logic [BIN_W-1:0]             bin,
    output logic                         ready,
    output logic                         done,
    output logic                         overflow,
    output logic                         commit,
    output logic [FND_DIGITS*BCD_W-1:0]  bcd
);

    state_t                        state;
    state_t                        state_next;
    logic [3:0]                    cnt;
    logic [BIN_W-1:0]              sh;
    logic [FND_DIGITS*BCD_W-1:0]   scratch;
    logic [FND_DIGITS*BCD_W-1:0]   adj;
    logic                          xfer;
    logic                          too_big;

    assign xfer    = valid && ready;
    assign too_big = bin > BIN_W'(MAX_VALUE);
    assign adj     = add3(scratch);
    assign commit  = (state == COMMIT);
    assign bcd     = scratch;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (xfer) state_next = SHIFT;
            SHIFT:   if (cnt == 4'(BIN_W - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            scratch  <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state_next == IDLE);
            done  <= (state == COMMIT);
            case (state)
                IDLE: begin
                    if (xfer) begin
                        sh      <= too_big ? BIN_W'(MAX_VALUE) : bin;
                        cnt     <= '0;
                        scratch <= '0;
                        if (too_big) overflow <= 1'b1;
                    end
                end
                SHIFT: begin
                    scratch <= {adj[FND_DIGITS*BCD_W-2:0], sh[BIN_W-1]};
                    sh      <= {sh[BIN_W-2:0], 1'b0};
                    cnt     <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// FND source: converts accepted binary values to BCD, holds them in a display
// register and time-multiplexes the four digits with optional zero blanking.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    input  logic [BIN_W-1:0]  i_bin,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_overflow,
    output logic [1:0]        o_digitSelect,
    output logic [BCD_W-1:0]  o_bcd,
    output logic              o_en
);

    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic                          commit;
    logic [FND_DIGITS*BCD_W-1:0]   bcd;
    logic [FND_DIGITS*BCD_W-1:0]   display;
    logic [PW-1:0]                 prescaler;
    logic [FND_DIGITS-1:0]         nz;

    binary_to_bcd_seq u_conv (
        .clk      (i_clk),
        .reset_n  (i_reset_n),
        .valid    (i_valid),
        .bin      (i_bin),
        .ready    (o_ready),
        .done     (o_done),
        .overflow (o_overflow),
        .commit   (commit),
        .bcd      (bcd)
    );

    // Scan timing free-runs; commits only touch the display register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            display       <= '0;
            prescaler     <= '0;
            o_digitSelect <= '0;
        end else begin
            if (commit) display <= bcd;
            if (prescaler == PW'(SCAN_DIV - 1)) begin
                prescaler     <= '0;
                o_digitSelect <= o_digitSelect + 2'd1;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    assign o_bcd = display[{o_digitSelect, 2'b00} +: BCD_W];

    // nz[n]: digit n or any higher digit is non-zero; digit 0 always lit.
    always_comb begin
        nz    = '0;
        nz[3] = |display[15:12];
        nz[2] = nz[3] | (|display[11:8]);
        nz[1] = nz[2] | (|display[7:4]);
        nz[0] = 1'b1;
    end

    always_comb begin
        o_en = 1'b1;
        if (BLANK_LZ != 0) o_en = nz[o_digitSelect];
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed self-checking bench for fnd_scan_controller with SCAN_DIV=4,
// comparing a blanking instance against a non-blanking one.
module tb_fnd_scan_controller;

    logic        clk;
    logic        reset_n;
    logic        valid;
    logic [13:0] bin;

    logic        ready_a, done_a, ovf_a, en_a;
    logic [1:0]  sel_a;
    logic [3:0]  bcd_a;
    logic        ready_b, done_b, ovf_b, en_b;
    logic [1:0]  sel_b;
    logic [3:0]  bcd_b;

    int tests = 0;
    int fails = 0;
    int unsigned ncyc = 0;

    logic [13:0] bvals [0:7] = '{14'd0, 14'd9, 14'd10, 14'd99, 14'd100, 14'd999, 14'd1000, 14'd9999};
    logic [15:0] bexp  [0:7] = '{16'h0000, 16'h0009, 16'h0010, 16'h0099,
                                 16'h0100, 16'h0999, 16'h1000, 16'h9999};
    logic [3:0]  bmask [0:7] = '{4'b0001, 4'b0001, 4'b0011, 4'b0011,
                                 4'b0111, 4'b0111, 4'b1111, 4'b1111};

    fnd_scan_controller #(.SCAN_DIV(4), .BLANK_LZ(1)) dut_a (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_valid       (valid),
        .i_bin         (bin),
        .o_ready       (ready_a),
        .o_done        (done_a),
        .o_overflow    (ovf_a),
        .o_digitSelect (sel_a),
        .o_bcd         (bcd_a),
        .o_en          (en_a)
    );

    fnd_scan_controller #(.SCAN_DIV(4), .BLANK_LZ(0)) dut_b (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_valid       (valid),
        .i_bin         (bin),
        .o_ready       (ready_b),
        .o_done        (done_b),
        .o_overflow    (ovf_b),
        .o_digitSelect (sel_b),
        .o_bcd         (bcd_b),
        .o_en          (en_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edges since the last reset edge; the digit index is (ncyc/4)%4.
    always @(posedge clk) begin
        if (!reset_n) ncyc <= 0;
        else          ncyc <= ncyc + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [13:0] v);
        int n;
        n = 0;
        while (!ready_a && n < 40) begin
            tick;
            n++;
        end
        chk("send_ready", 16'(ready_a), 16'd1);
        valid = 1'b1;
        bin   = v;
        tick;
        valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_a && n < 20) begin
            tick;
            n++;
        end
        chk(tag, 16'(done_a), 16'd1);
    endtask

    task automatic check_disp(input string tag, input logic [15:0] exp,
                              input logic [3:0] ma, input logic [3:0] mb);
        int n;
        for (int d = 0; d < 4; d++) begin
            n = 0;
            while (sel_a != 2'(d) && n < 20) begin
                tick;
                n++;
            end
            chk({tag, "_sel"},      16'(sel_a), 16'(d));
            chk({tag, "_selmodel"}, 16'(sel_a), 16'((ncyc / 4) % 4));
            chk({tag, "_selb"},     16'(sel_b), 16'(sel_a));
            chk({tag, "_bcd_a"},    16'(bcd_a), 16'(exp[d*4 +: 4]));
            chk({tag, "_bcd_b"},    16'(bcd_b), 16'(exp[d*4 +: 4]));
            chk({tag, "_en_a"},     16'(en_a),  16'(ma[d]));
            chk({tag, "_en_b"},     16'(en_b),  16'(mb[d]));
        end
    endtask

    initial begin
        int n;
        int h;
        int dn;
        logic [1:0] prev;

        reset_n = 1'b0;
        valid   = 1'b0;
        bin     = '0;
        tick;
        tick;
        chk("rst_ready", 16'(ready_a), 16'd1);
        chk("rst_done",  16'(done_a),  16'd0);
        chk("rst_ovf",   16'(ovf_a),   16'd0);
        chk("rst_sel",   16'(sel_a),   16'd0);
        chk("rst_bcd",   16'(bcd_a),   16'd0);
        chk("rst_en",    16'(en_a),    16'd1);
        reset_n = 1'b1;

        // Each digit slot lasts SCAN_DIV cycles.
        prev = sel_a;
        n = 0;
        while (sel_a == prev && n < 20) begin tick; n++; end
        prev = sel_a;
        h = 0;
        while (sel_a == prev && h < 20) begin tick; h++; end
        chk("slot_len", 16'(h), 16'd4);

        // 1234: ready falls after transfer, done exactly at +15.
        valid = 1'b1;
        bin   = 14'd1234;
        tick;
        valid = 1'b0;
        chk("t1_ready_low", 16'(ready_a), 16'd0);
        for (int i = 1; i <= 14; i++) begin
            tick;
            chk("t1_done_early", 16'(done_a), 16'd0);
        end
        tick;
        chk("t1_done",     16'(done_a),  16'd1);
        chk("t1_ready_hi", 16'(ready_a), 16'd1);
        tick;
        chk("t1_done_end", 16'(done_a),  16'd0);
        check_disp("t1", 16'h1234, 4'b1111, 4'b1111);

        send(14'd7);
        wait_done("t7_done");
        check_disp("t7", 16'h0007, 4'b0001, 4'b1111);

        send(14'd12000);
        wait_done("ovf_done");
        chk("ovf_set", 16'(ovf_a), 16'd1);
        check_disp("ovf", 16'h9999, 4'b1111, 4'b1111);
        send(14'd42);
        wait_done("t42_done");
        chk("ovf_sticky", 16'(ovf_a), 16'd1);
        check_disp("t42", 16'h0042, 4'b0011, 4'b1111);

        // A valid while busy must be dropped, not queued.
        send(14'd5555);
        tick;
        tick;
        valid = 1'b1;
        bin   = 14'd1111;
        tick;
        valid = 1'b0;
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            tick;
            if (done_a) dn++;
        end
        chk("busy_one_done", 16'(dn), 16'd1);
        check_disp("busy", 16'h5555, 4'b1111, 4'b1111);

        // Reset in the middle of a conversion.
        send(14'd9999);
        for (int i = 0; i < 6; i++) tick;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        chk("mid_rst_ready", 16'(ready_a), 16'd1);
        chk("mid_rst_sel",   16'(sel_a),   16'd0);
        chk("mid_rst_bcd",   16'(bcd_a),   16'd0);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (done_a) dn++;
        end
        chk("mid_rst_nodone", 16'(dn), 16'd0);
        check_disp("mid_rst", 16'h0000, 4'b0001, 4'b1111);

        for (int i = 0; i < 8; i++) begin
            send(bvals[i]);
            wait_done("bnd_done");
            chk("bnd_sel_at_commit", 16'(sel_a), 16'((ncyc / 4) % 4));
            check_disp("bnd", bexp[i], bmask[i], 4'b1111);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
